ul_srch_seg_pwr_acc: RTL and testbench
======================================

// Module: ul_srch_seg_pwr_acc
// PURPOSE
//  Per-900kHz-segment RE power accumulator for UL search; sits directly downstream of the 900k segment mapper.
//  Consumes a stream of RE power samples tagged with mapper outputs (seg, mod) and sums power per segment.
//  Emits one result per segment: seg index, power sum, RE count and a full-segment flag.
//  Results feed the segment-energy ranking stage via a valid/ready interface.
// PARAMETERS
//  PWR_W   16  RE power sample width, unsigned
//  ACC_W   24  accumulator/result width, unsigned, saturating
// PORTS
//  clk        in   1      clock, single domain
//  rst_n      in   1      asynchronous active-low reset
//  sym_start  in   1      symbol start pulse; samples scs, aborts open segment
//  scs        in   2      0 off, 1 -> seg len 180, 2 -> 60, 3 -> 30
//  in_vld     in   1      input sample valid
//  in_rdy     out  1      input ready
//  in_seg     in   8      segment index from mapper
//  in_mod     in   8      RE offset within segment from mapper
//  in_pwr     in   PWR_W  RE power
//  in_last    in   1      last RE of symbol; forces flush
//  out_vld    out  1      result valid
//  out_rdy    in   1      result ready
//  out_seg    out  8      segment index of result
//  out_pwr    out  ACC_W  saturated power sum
//  out_cnt    out  8      number of REs accumulated
//  out_full   out  1      out_cnt == seg len
//  err_order  out  1      sticky: non-increasing in_mod within a segment
// BEHAVIOUR
//  - Reset: all outputs 0 except in_rdy=1; state IDLE; scs_q=0.
//  - sym_start: scs_q<=scs; open segment discarded (no emission); err_order<=0; state IDLE.
//    Pending/output results already formed are kept. Input beat in same cycle as sym_start is ignored.
//  - scs_q==0: in_rdy=1; all beats dropped; no results.
//  - Accept = in_vld & in_rdy. in_rdy = !pend_vld & (!out_vld | out_rdy).
//  - States: IDLE (no open segment), ACC (open segment cur_seg, acc, cnt, last_mod).
//  - IDLE + accept: cur_seg<=in_seg, acc<=in_pwr, cnt<=1, last_mod<=in_mod; go ACC.
//  - ACC + accept, in_seg==cur_seg: acc<=sat(acc+in_pwr), cnt+1, last_mod<=in_mod.
//    Set err_order if in_mod<=last_mod.
//  - ACC + accept, in_seg!=cur_seg: emit old segment; open new one with the beat (as IDLE).
//  - Close: after update, if in_mod==len-1 or in_last, emit the (new) segment; go IDLE.
//    If a jump and a close coincide, two results: older to out, newer to pend.
//  - Result slots: out register plus one pending register; pend moves to out when out drains.
//  - Latency: beat closing a segment -> out_vld next cycle (pend case: +1 after out handshake).
//  - Saturation: acc clamps to 2^ACC_W-1, never wraps. cnt max 180, fits 8b.
//  - out_* stable while out_vld & !out_rdy. out_full = (cnt==len(scs_q)).
// STRUCTURE
//  - Shared pkg: SEG_LEN_SCS5=180, SEG_LEN_SCS15=60, SEG_LEN_SCS30=30, SCS_* codes, result struct fields.
//  - Sub-module ul_srch_seg_sat_add: ACC_W + PWR_W saturating adder, combinational.
//  - Top holds the FSM, counters, out/pend registers.
// TESTING
//  - scs=3, RE 0..29 pwr=1 each -> one result seg0 pwr=30 cnt=30 full=1.
//  - scs=2, RE 0..119 pwr=2 -> results seg0, seg1, each pwr=120 cnt=60 full=1.
//  - scs=1, beats seg0 mod 0..9, then seg1 mod0 with in_last=1:
//    results seg0 (cnt10, full0), then seg1 (cnt1). pend used; in_rdy low one cycle.
//  - out_rdy held low 20 cycles mid-stream: in_rdy drops once out+pend are full; no result lost; out_* stable.
//  - PWR_W=16, ACC_W=16, two beats pwr=0xFFFF -> out_pwr=0xFFFF (saturated).
//  - Reset or sym_start mid-segment -> no partial result; seg1 mod 5 then mod 3 -> err_order=1 until sym_start.

Source files
------------

// File: rtl/ul_srch_seg_pwr_acc_pkg.sv
// Shared definitions for the UL search per-segment RE power accumulator:
// subcarrier-spacing codes, segment lengths, FSM states and result metadata.
package ul_srch_seg_pwr_acc_pkg;

    localparam logic [1:0] SCS_OFF = 2'd0;
    localparam logic [1:0] SCS_5   = 2'd1;
    localparam logic [1:0] SCS_15  = 2'd2;
    localparam logic [1:0] SCS_30  = 2'd3;

    localparam logic [7:0] SEG_LEN_SCS5  = 8'd180;
    localparam logic [7:0] SEG_LEN_SCS15 = 8'd60;
    localparam logic [7:0] SEG_LEN_SCS30 = 8'd30;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // Everything of a result except the power sum, whose width is a parameter.
    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] cnt;
        logic       full;
    } res_meta_t;

    // Number of REs in one 900 kHz segment for a given spacing code.
    function automatic logic [7:0] seg_len(input logic [1:0] scs);
        logic [7:0] len;
        case (scs)
            SCS_5:   len = SEG_LEN_SCS5;
            SCS_15:  len = SEG_LEN_SCS15;
            SCS_30:  len = SEG_LEN_SCS30;
            default: len = 8'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ul_srch_seg_pwr_acc_sat_add.sv
// Saturating adder: ACC_W-bit accumulator plus PWR_W-bit sample, clamped
// to all-ones on overflow. Assumes ACC_W >= PWR_W.
module ul_srch_seg_sat_add #(
    parameter int ACC_W = 24,
    parameter int PWR_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [PWR_W-1:0] add,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W:0] wide_s;

    // Widen by one bit so the carry out flags overflow, then clamp.
    always_comb begin
        wide_s = {1'b0, acc} + {{(ACC_W + 1 - PWR_W){1'b0}}, add};
        if (wide_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = wide_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/ul_srch_seg_pwr_acc.sv
// Per-900kHz-segment RE power accumulator. Sums tagged RE power per segment
// and emits one result per segment through an out register backed by one
// pending register (needed when a segment jump and a close coincide).
module ul_srch_seg_pwr_acc
    import ul_srch_seg_pwr_acc_pkg::*;
#(
    parameter int PWR_W = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sym_start,
    input  logic [1:0]       scs,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [7:0]       in_seg,
    input  logic [7:0]       in_mod,
    input  logic [PWR_W-1:0] in_pwr,
    input  logic             in_last,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [7:0]       out_seg,
    output logic [ACC_W-1:0] out_pwr,
    output logic [7:0]       out_cnt,
    output logic             out_full,
    output logic             err_order
);

    logic [1:0]       scs_q_r;
    state_t           state_r;
    state_t           state_s;
    logic [7:0]       cur_seg_r;
    logic [ACC_W-1:0] acc_r;
    logic [7:0]       cnt_r;
    logic [7:0]       last_mod_r;
    logic             err_order_r;

    logic             out_vld_r;
    res_meta_t        out_meta_r;
    logic [ACC_W-1:0] out_pwr_r;
    logic             pend_vld_r;
    res_meta_t        pend_meta_r;
    logic [ACC_W-1:0] pend_pwr_r;

    logic [7:0]       seg_len_s;
    logic             in_rdy_s;
    logic             accept_s;
    logic             same_seg_s;
    logic             jump_s;
    logic             close_s;
    logic             order_err_s;
    logic [ACC_W-1:0] sum_s;
    logic [ACC_W-1:0] nxt_acc_s;
    logic [7:0]       nxt_cnt_s;
    res_meta_t        jump_meta_s;
    res_meta_t        close_meta_s;

    ul_srch_seg_sat_add #(
        .ACC_W (ACC_W),
        .PWR_W (PWR_W)
    ) u_sat_add (
        .acc (acc_r),
        .add (in_pwr),
        .sum (sum_s)
    );

    // With spacing off every beat is swallowed; otherwise a beat can only be
    // taken when both result slots can absorb up to two new results.
    assign seg_len_s   = seg_len(scs_q_r);
    assign in_rdy_s    = (scs_q_r == SCS_OFF) | (!pend_vld_r & (!out_vld_r | out_rdy));
    assign accept_s    = in_vld & in_rdy_s & !sym_start & (scs_q_r != SCS_OFF);
    assign same_seg_s  = (state_r == ST_ACC) & (in_seg == cur_seg_r);
    assign jump_s      = accept_s & (state_r == ST_ACC) & !same_seg_s;
    assign close_s     = accept_s & ((in_mod == (seg_len_s - 8'd1)) | in_last);
    assign order_err_s = accept_s & same_seg_s & (in_mod <= last_mod_r);

    // Open-segment update values and the two possible results of this beat.
    always_comb begin
        nxt_acc_s = ACC_W'(in_pwr);
        nxt_cnt_s = 8'd1;
        if (same_seg_s) begin
            nxt_acc_s = sum_s;
            if (cnt_r == 8'hFF) begin
                nxt_cnt_s = cnt_r;
            end else begin
                nxt_cnt_s = cnt_r + 8'd1;
            end
        end else begin
            nxt_acc_s = ACC_W'(in_pwr);
            nxt_cnt_s = 8'd1;
        end
        jump_meta_s.seg   = cur_seg_r;
        jump_meta_s.cnt   = cnt_r;
        jump_meta_s.full  = (cnt_r == seg_len_s);
        close_meta_s.seg  = in_seg;
        close_meta_s.cnt  = nxt_cnt_s;
        close_meta_s.full = (nxt_cnt_s == seg_len_s);
    end

    // Next-state: symbol start always returns to IDLE; a closing beat ends the
    // segment, any other accepted beat leaves one open.
    always_comb begin
        state_s = state_r;
        if (sym_start) begin
            state_s = ST_IDLE;
        end else if (accept_s) begin
            if (close_s) begin
                state_s = ST_IDLE;
            end else begin
                state_s = ST_ACC;
            end
        end else begin
            state_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Spacing latch and sticky ordering error, both re-armed at symbol start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scs_q_r     <= SCS_OFF;
            err_order_r <= 1'b0;
        end else if (sym_start) begin
            scs_q_r     <= scs;
            err_order_r <= 1'b0;
        end else if (order_err_s) begin
            err_order_r <= 1'b1;
        end
    end

    // Open-segment registers; a jump reopens them with the jumping beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_seg_r  <= 8'd0;
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= 8'd0;
            last_mod_r <= 8'd0;
        end else if (accept_s) begin
            cur_seg_r  <= in_seg;
            acc_r      <= nxt_acc_s;
            cnt_r      <= nxt_cnt_s;
            last_mod_r <= in_mod;
        end
    end

    // Result slots: pending refills out when out drains; otherwise the older
    // new result goes to out and a second (newer) one to pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_r   <= 1'b0;
            out_meta_r  <= '{seg: 8'd0, cnt: 8'd0, full: 1'b0};
            out_pwr_r   <= {ACC_W{1'b0}};
            pend_vld_r  <= 1'b0;
            pend_meta_r <= '{seg: 8'd0, cnt: 8'd0, full: 1'b0};
            pend_pwr_r  <= {ACC_W{1'b0}};
        end else if (pend_vld_r) begin
            if (!out_vld_r | out_rdy) begin
                out_vld_r  <= 1'b1;
                out_meta_r <= pend_meta_r;
                out_pwr_r  <= pend_pwr_r;
                pend_vld_r <= 1'b0;
            end
        end else if (jump_s) begin
            out_vld_r  <= 1'b1;
            out_meta_r <= jump_meta_s;
            out_pwr_r  <= acc_r;
            if (close_s) begin
                pend_vld_r  <= 1'b1;
                pend_meta_r <= close_meta_s;
                pend_pwr_r  <= nxt_acc_s;
            end
        end else if (close_s) begin
            out_vld_r  <= 1'b1;
            out_meta_r <= close_meta_s;
            out_pwr_r  <= nxt_acc_s;
        end else if (out_vld_r & out_rdy) begin
            out_vld_r <= 1'b0;
        end
    end

    assign in_rdy    = in_rdy_s;
    assign out_vld   = out_vld_r;
    assign out_seg   = out_meta_r.seg;
    assign out_cnt   = out_meta_r.cnt;
    assign out_full  = out_meta_r.full;
    assign out_pwr   = out_pwr_r;
    assign err_order = err_order_r;

endmodule

// File: tb/tb_ul_srch_seg_pwr_acc.sv
// Self-checking bench for ul_srch_seg_pwr_acc: directed vectors, a
// transaction-level model producing expected results, a per-cycle monitor,
// and literal expectations on the observed result log.
module tb_ul_srch_seg_pwr_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sym_start;
    logic [1:0]  scs;
    logic        in_vld;
    logic        in_rdy;
    logic [7:0]  in_seg;
    logic [7:0]  in_mod;
    logic [15:0] in_pwr;
    logic        in_last;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  out_seg;
    logic [23:0] out_pwr;
    logic [7:0]  out_cnt;
    logic        out_full;
    logic        err_order;

    // second instance, 16-bit accumulator, for saturation
    logic        s_sym_start;
    logic [1:0]  s_scs;
    logic        s_in_vld;
    logic        s_in_rdy;
    logic [7:0]  s_in_seg;
    logic [7:0]  s_in_mod;
    logic [15:0] s_in_pwr;
    logic        s_in_last;
    logic        s_out_vld;
    logic        s_out_rdy;
    logic [7:0]  s_out_seg;
    logic [15:0] s_out_pwr;
    logic [7:0]  s_out_cnt;
    logic        s_out_full;
    logic        s_err_order;

    always #5 clk = ~clk;

    ul_srch_seg_pwr_acc #(.PWR_W(16), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .sym_start(sym_start), .scs(scs),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_seg(in_seg), .in_mod(in_mod),
        .in_pwr(in_pwr), .in_last(in_last), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_seg(out_seg), .out_pwr(out_pwr), .out_cnt(out_cnt),
        .out_full(out_full), .err_order(err_order)
    );

    ul_srch_seg_pwr_acc #(.PWR_W(16), .ACC_W(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .sym_start(s_sym_start), .scs(s_scs),
        .in_vld(s_in_vld), .in_rdy(s_in_rdy), .in_seg(s_in_seg), .in_mod(s_in_mod),
        .in_pwr(s_in_pwr), .in_last(s_in_last), .out_vld(s_out_vld), .out_rdy(s_out_rdy),
        .out_seg(s_out_seg), .out_pwr(s_out_pwr), .out_cnt(s_out_cnt),
        .out_full(s_out_full), .err_order(s_err_order)
    );

    typedef struct {
        int seg;
        int pwr;
        int cnt;
        int full;
    } res_t;

    res_t exp_q[$];
    res_t log_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // transaction-level model state
    int scs_m   = 0;
    bit m_open  = 1'b0;
    int m_seg, m_acc, m_cnt, m_last_mod;
    bit err_exp = 1'b0;
    bit err_exp_q = 1'b0;

    localparam int ACC_MAX = (1 << 24) - 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int len_of(input int s);
        case (s)
            1: return 180;
            2: return 60;
            3: return 30;
            default: return 0;
        endcase
    endfunction

    function automatic void push_res(input int seg, input int pwr, input int cnt);
        res_t r;
        r.seg  = seg;
        r.pwr  = pwr;
        r.cnt  = cnt;
        r.full = (cnt == len_of(scs_m)) ? 1 : 0;
        exp_q.push_back(r);
    endfunction

    // Apply the accumulation rules to one accepted beat.
    function automatic void model_beat(input int seg, input int mod, input int pwr, input bit last);
        if (scs_m == 0) return;
        if (m_open && seg == m_seg) begin
            m_acc = (m_acc + pwr > ACC_MAX) ? ACC_MAX : m_acc + pwr;
            m_cnt = m_cnt + 1;
            if (mod <= m_last_mod) err_exp = 1'b1;
            m_last_mod = mod;
        end else begin
            if (m_open) push_res(m_seg, m_acc, m_cnt);
            m_open = 1'b1;
            m_seg = seg;
            m_acc = pwr;
            m_cnt = 1;
            m_last_mod = mod;
        end
        if (mod == len_of(scs_m) - 1 || last) begin
            push_res(m_seg, m_acc, m_cnt);
            m_open = 1'b0;
        end
    endfunction

    always @(posedge clk) err_exp_q <= err_exp;

    // Monitor: scoreboard on every output handshake, stability under
    // backpressure, and err_order tracking every cycle.
    bit          hold_prev = 1'b0;
    logic [7:0]  p_seg;
    logic [23:0] p_pwr;
    logic [7:0]  p_cnt;
    logic        p_full;
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (hold_prev) begin
                chk("out_stable_vld", out_vld, 1);
                chk("out_stable_fields", {out_seg, out_pwr, out_cnt, out_full},
                    {p_seg, p_pwr, p_cnt, p_full});
            end
            if (out_vld && out_rdy) begin
                res_t g;
                g.seg = out_seg; g.pwr = out_pwr; g.cnt = out_cnt; g.full = out_full;
                log_q.push_back(g);
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL result_unexpected: got seg=%0d pwr=%0d cnt=%0d full=%0d, expected none",
                             g.seg, g.pwr, g.cnt, g.full);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    if (e == g) begin
                        n_pass++;
                    end else begin
                        $display("FAIL result: got seg=%0d pwr=%0d cnt=%0d full=%0d expected seg=%0d pwr=%0d cnt=%0d full=%0d",
                                 g.seg, g.pwr, g.cnt, g.full, e.seg, e.pwr, e.cnt, e.full);
                    end
                end
            end
            chk("err_order", err_order, err_exp_q);
            hold_prev = out_vld && !out_rdy;
            p_seg = out_seg; p_pwr = out_pwr; p_cnt = out_cnt; p_full = out_full;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Drive one beat; called at a falling edge, returns at a falling edge.
    task automatic send(input int seg, input int mod, input int pwr, input bit last);
        int waited;
        waited = 0;
        in_seg = seg[7:0]; in_mod = mod[7:0]; in_pwr = pwr[15:0]; in_last = last;
        in_vld = 1'b1;
        #1;
        while (!in_rdy && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_rdy) begin
            chk("in_rdy_timeout", 0, 1);
            @(negedge clk);
            in_vld = 1'b0;
            return;
        end
        model_beat(seg, mod, pwr, last);
        @(negedge clk);
        in_vld = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic do_sym(input int s);
        sym_start = 1'b1;
        scs = s[1:0];
        scs_m = s;
        m_open = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        sym_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_log(input string name, input int idx, input int seg, input int pwr,
                           input int cnt, input int full);
        if (idx >= log_q.size()) begin
            chk({name, "_present"}, 0, 1);
        end else begin
            chk({name, "_seg"}, log_q[idx].seg, seg);
            chk({name, "_pwr"}, log_q[idx].pwr, pwr);
            chk({name, "_cnt"}, log_q[idx].cnt, cnt);
            chk({name, "_full"}, log_q[idx].full, full);
        end
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_out_vld"}, out_vld, 0);
        chk({name, "_in_rdy"}, in_rdy, 1);
        chk({name, "_out_seg"}, out_seg, 0);
        chk({name, "_out_pwr"}, out_pwr, 0);
        chk({name, "_out_cnt"}, out_cnt, 0);
        chk({name, "_out_full"}, out_full, 0);
        chk({name, "_err_order"}, err_order, 0);
    endtask

    initial begin
        rst_n = 1'b0; sym_start = 1'b0; scs = 2'd0;
        in_vld = 1'b0; in_seg = 8'd0; in_mod = 8'd0; in_pwr = 16'd0; in_last = 1'b0;
        out_rdy = 1'b1;
        s_sym_start = 1'b0; s_scs = 2'd0; s_in_vld = 1'b0; s_in_seg = 8'd0;
        s_in_mod = 8'd0; s_in_pwr = 16'd0; s_in_last = 1'b0; s_out_rdy = 1'b1;
        idle(3);
        #1;
        chk_reset_state("reset");
        chk("reset_sat_in_rdy", s_in_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // spacing off: beats dropped
        log_q.delete();
        for (int i = 0; i < 10; i++) send(0, i, 1, 1'b0);
        idle(4);
        chk("scs_off_no_result", log_q.size(), 0);

        // scs=3, 30 REs pwr 1
        do_sym(3);
        log_q.delete();
        for (int i = 0; i < 30; i++) send(0, i, 1, 1'b0);
        idle(4);
        chk("t1_count", log_q.size(), 1);
        chk_log("t1_r0", 0, 0, 30, 30, 1);

        // scs=2, 120 REs pwr 2
        do_sym(2);
        log_q.delete();
        for (int i = 0; i < 120; i++) send(i / 60, i % 60, 2, 1'b0);
        idle(4);
        chk("t2_count", log_q.size(), 2);
        chk_log("t2_r0", 0, 0, 120, 60, 1);
        chk_log("t2_r1", 1, 1, 120, 60, 1);

        // scs=1, seg0 mod 0..9 then seg1 mod0 last: jump + close together
        do_sym(1);
        log_q.delete();
        for (int i = 0; i < 10; i++) send(0, i, 1, 1'b0);
        send(1, 0, 1, 1'b1);
        #1;
        chk("t3_in_rdy_low", in_rdy, 0);
        @(negedge clk);
        #1;
        chk("t3_in_rdy_back", in_rdy, 1);
        @(negedge clk);
        idle(3);
        chk("t3_count", log_q.size(), 2);
        chk_log("t3_r0", 0, 0, 10, 10, 0);
        chk_log("t3_r1", 1, 1, 1, 1, 0);

        // backpressure: out_rdy low 20 cycles mid-stream
        do_sym(3);
        log_q.delete();
        fork
            begin
                for (int s = 0; s < 3; s++) begin
                    send(s, 0, 5, 1'b0);
                    send(s, 1, 5, 1'b1);
                end
            end
            begin
                out_rdy = 1'b0;
                repeat (10) @(negedge clk);
                #1;
                chk("t4_in_rdy_low", in_rdy, 0);
                chk("t4_out_vld_held", out_vld, 1);
                repeat (10) @(negedge clk);
                out_rdy = 1'b1;
            end
        join
        idle(5);
        chk("t4_count", log_q.size(), 3);
        chk_log("t4_r0", 0, 0, 10, 2, 0);
        chk_log("t4_r1", 1, 1, 10, 2, 0);
        chk_log("t4_r2", 2, 2, 10, 2, 0);

        // sym_start mid-segment discards, then ordering error
        do_sym(3);
        log_q.delete();
        for (int i = 0; i < 5; i++) send(0, i, 1, 1'b0);
        do_sym(3);
        idle(3);
        chk("t6_abort_no_result", log_q.size(), 0);
        send(1, 5, 1, 1'b0);
        send(1, 3, 1, 1'b0);
        idle(2);
        #1;
        chk("t6_err_set", err_order, 1);
        @(negedge clk);
        do_sym(3);
        #1;
        chk("t6_err_cleared", err_order, 0);
        @(negedge clk);
        idle(3);
        chk("t6_no_partial", log_q.size(), 0);

        // reset mid-segment
        for (int i = 0; i < 4; i++) send(2, i, 1, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        m_open = 1'b0; scs_m = 0; err_exp = 1'b0;
        idle(2);
        #1;
        chk_reset_state("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        chk("reset_no_partial", log_q.size(), 0);

        // saturation on the 16-bit accumulator instance
        s_sym_start = 1'b1; s_scs = 2'd3;
        @(negedge clk);
        s_sym_start = 1'b0;
        s_in_vld = 1'b1; s_in_seg = 8'd0; s_in_mod = 8'd0; s_in_pwr = 16'hFFFF; s_in_last = 1'b0;
        @(negedge clk);
        s_in_mod = 8'd1; s_in_last = 1'b1;
        @(negedge clk);
        s_in_vld = 1'b0; s_in_last = 1'b0;
        #1;
        chk("sat_out_vld", s_out_vld, 1);
        chk("sat_out_pwr", s_out_pwr, 16'hFFFF);
        chk("sat_out_cnt", s_out_cnt, 2);
        chk("sat_out_seg", s_out_seg, 0);
        chk("sat_out_full", s_out_full, 0);
        chk("sat_err_order", s_err_order, 0);
        @(negedge clk);
        idle(2);

        chk("model_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
